// File: rtl/rf_wr_arb.sv
// rtl/rf_wr_arb.sv - two-requester round-robin register-file write arbiter
module rf_wr_arb #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [4:0]       req0_addr,
  input  logic [31:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [4:0]       req1_addr,
  input  logic [31:0]      req1_data,
  output logic             req1_ready,
  output logic             we3,
  output logic [4:0]       wa3,
  output logic [31:0]      wd3,
  output logic [CNT_W-1:0] stall_cnt
);

  // Last-grant pointer: 1 after reset so requester 0 wins the first conflict.
  logic        lg;
  logic        xfer;
  logic        stall;
  logic        wr_ok;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  // Readies depend only on valids, lg and reset; never on addr/data.
  assign req0_ready = reset_n & req0_valid & (~req1_valid | lg);
  assign req1_ready = reset_n & req1_valid & (~req0_valid | ~lg);

  // Select the granted payload and classify the cycle.
  always_comb begin
    xfer     = req0_ready | req1_ready;
    sel_addr = req1_ready ? req1_addr : req0_addr;
    sel_data = req1_ready ? req1_data : req0_data;
    wr_ok    = xfer && (sel_addr != 5'd0);
    stall    = (req0_valid & ~req0_ready) | (req1_valid & ~req1_ready);
  end

  // Last-grant pointer follows the accepted requester, holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lg <= 1'b1;
    end else if (xfer) begin
      lg <= req1_ready;
    end
  end

  // Registered write port; address-0 writes are swallowed and wa3/wd3 hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we3 <= 1'b0;
      wa3 <= 5'd0;
      wd3 <= 32'd0;
    end else begin
      we3 <= wr_ok;
      if (wr_ok) begin
        wa3 <= sel_addr;
        wd3 <= sel_data;
      end
    end
  end

  // Saturating count of cycles where some valid requester was turned away.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rf_wr_arb.sv
// tb/tb_rf_wr_arb.sv - self-checking bench for rf_wr_arb
module tb_rf_wr_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, req0_ready_s, req1_ready_s;
  logic        we3, we3_s;
  logic [4:0]  wa3, wa3_s;
  logic [31:0] wd3, wd3_s;
  logic [7:0]  stall_cnt;
  logic [1:0]  stall_cnt_s;

  always #5 clk = ~clk;

  rf_wr_arb #(.CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .we3(we3), .wa3(wa3), .wd3(wd3), .stall_cnt(stall_cnt)
  );

  rf_wr_arb #(.CNT_W(2)) dut_s (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready_s),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready_s),
    .we3(we3_s), .wa3(wa3_s), .wd3(wd3_s), .stall_cnt(stall_cnt_s)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          m_lg;
  int          m_cnt;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          w0, w1;
  logic        last_g0, last_g1;

  typedef struct {
    logic        v0; logic [4:0] a0; logic [31:0] d0;
    logic        v1; logic [4:0] a1; logic [31:0] d1;
    logic        r0; logic r1;
    logic        we; logic [4:0] wa; logic [31:0] wd;
    int          cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_lg = 1; m_cnt = 0; m_we = 0; m_wa = 0; m_wd = 0; w0 = 0; w1 = 0;
    last_g0 = 0; last_g1 = 0;
  endtask

  // One cycle: starts just after a rising edge, ends 1 time unit after the next.
  task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    int winner;
    logic g0, g1;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    // Winner: the only valid requester, or on conflict whoever did not win last.
    if (v0 && v1)  winner = 1 - m_lg;
    else if (v0)   winner = 0;
    else if (v1)   winner = 1;
    else           winner = -1;
    g0 = (winner == 0);
    g1 = (winner == 1);
    #1;
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    chk("req0_ready_s", req0_ready_s, g0);
    @(posedge clk);
    if (winner >= 0) begin
      if (((winner == 0) ? a0 : a1) != 0) begin
        m_we = 1;
        m_wa = (winner == 0) ? a0 : a1;
        m_wd = (winner == 0) ? d0 : d1;
      end else begin
        m_we = 0;
      end
      m_lg = winner;
    end else begin
      m_we = 0;
    end
    if ((int'(v0) + int'(v1)) > (int'(g0) + int'(g1))) m_cnt++;
    w0 = (v0 && !g0) ? w0 + 1 : 0;
    w1 = (v1 && !g1) ? w1 + 1 : 0;
    last_g0 = g0; last_g1 = g1;
    #1;
    chk("we3", we3, m_we);
    chk("wa3", wa3, m_wa);
    chk("wd3", wd3, m_wd);
    chk("stall_cnt", stall_cnt, sat(m_cnt, 255));
    chk("stall_cnt_s", stall_cnt_s, sat(m_cnt, 3));
    chk("wait0_le1", w0 <= 1, 1);
    chk("wait1_le1", w1 <= 1, 1);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  // Reset pulse spanning a rising edge, released between edges.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    logic        hv0, hv1;
    logic [4:0]  ha0, ha1;
    logic [31:0] hd0, hd1;
    int pulses;

    // Table: after reset, lg=1, outputs 0
    vecs[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0,          1, 0, 1, 5, 32'hDEADBEEF, 0};
    vecs[1] = '{0, 0, 0,             0, 0, 0,          0, 0, 0, 5, 32'hDEADBEEF, 0};
    vecs[2] = '{0, 0, 0,             1, 0, 32'hFFFFFFFF, 0, 1, 0, 5, 32'hDEADBEEF, 0};
    vecs[3] = '{1, 1, 32'h11,        1, 2, 32'h22,     1, 0, 1, 1, 32'h11, 1};
    vecs[4] = '{0, 0, 0,             1, 2, 32'h22,     0, 1, 1, 2, 32'h22, 1};
    vecs[5] = '{0, 0, 0,             0, 0, 0,          0, 0, 0, 2, 32'h22, 1};

    // Reset state, with valids high to show readies are forced low
    reset_n = 1'b0;
    req0_valid = 1; req1_valid = 1;
    req0_addr = 3; req1_addr = 4; req0_data = 1; req1_data = 2;
    model_reset();
    #1;
    chk("rst_we3", we3, 0);
    chk("rst_wa3", wa3, 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_r0", req0_ready, 0);
    chk("rst_r1", req1_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold_we3", we3, 0);
    req0_valid = 0; req1_valid = 0;
    reset_n = 1'b1;

    // Table-driven directed vectors
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
      chk($sformatf("vec%0d_r0", i), last_g0, vecs[i].r0);
      chk($sformatf("vec%0d_r1", i), last_g1, vecs[i].r1);
      chk($sformatf("vec%0d_we3", i), we3, vecs[i].we);
      chk($sformatf("vec%0d_wa3", i), wa3, vecs[i].wa);
      chk($sformatf("vec%0d_wd3", i), wd3, vecs[i].wd);
      chk($sformatf("vec%0d_cnt", i), stall_cnt, vecs[i].cnt);
    end

    // Continuous dual requests: strict alternation, 10 writes, 10 stalls
    do_reset();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 3, 32'hA0, 1, 4, 32'hB1);
      chk("alt_g0", last_g0, (i % 2) == 0);
      chk("alt_g1", last_g1, (i % 2) == 1);
      if (we3) pulses++;
      if (i >= 2) chk("sat_cnt", stall_cnt_s, 3);
    end
    chk("dual_pulses", pulses, 10);
    chk("dual_cnt", stall_cnt, 10);
    idle();

    // Random traffic with requesters holding payload until accepted
    hv0 = 0; hv1 = 0; ha0 = 0; ha1 = 0; hd0 = 0; hd1 = 0;
    for (int i = 0; i < 800; i++) begin
      if (!hv0 || last_g0) begin
        hv0 = ($urandom_range(0, 99) < 60);
        ha0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        hd0 = $urandom;
      end
      if (!hv1 || last_g1) begin
        hv1 = ($urandom_range(0, 99) < 60);
        ha1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        hd1 = $urandom;
      end
      step(hv0, ha0, hd0, hv1, ha1, hd1);
    end

    // Reset mid-transfer: everything clears immediately, no write follows
    step(1, 3, 32'h33, 1, 4, 32'h44);
    req0_valid = 1; req0_addr = 9; req0_data = 32'h12345678;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    #1;
    chk("mid_r0_before", req0_ready, 1);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("mid_we3", we3, 0);
    chk("mid_wa3", wa3, 0);
    chk("mid_wd3", wd3, 0);
    chk("mid_cnt", stall_cnt, 0);
    chk("mid_cnt_s", stall_cnt_s, 0);
    chk("mid_r0", req0_ready, 0);
    chk("mid_r1", req1_ready, 0);
    @(posedge clk);
    #1;
    chk("mid_no_we3", we3, 0);
    chk("mid_no_wa3", wa3, 0);
    reset_n = 1'b1;
    step(1, 6, 32'h66, 1, 7, 32'h77);
    chk("post_rst_grant0", last_g0, 1);
    chk("post_rst_wa3", wa3, 6);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
